// File: rtl/col_uram_ctrl.sv
// col_uram_ctrl: load/read sequencer for the 64-URAM column store holding B transposed.
// Optional macro COL_URAM_CTRL_PERF_EN adds perf_stall_cycles / perf_issue_cycles outputs.
module col_uram_ctrl #(
  parameter int NUM_URAM        = 64,
  parameter int URAM_ADDR_WIDTH = 12,
  parameter int LOAD_DEPTH      = 256,
  parameter int READ_DEPTH      = 256,
  parameter int RD_LATENCY      = 3,
  parameter int FIFO_DEPTH      = 4,
  localparam int NUM_BANKS      = NUM_URAM / 16,
  localparam int BANK_W         = $clog2(NUM_BANKS),
  localparam int BANK_BITS      = 16 * 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_start,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       load_err,
  input  logic [63:0]                s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       s_tlast,
  input  logic                       rd_start,
  output logic                       rd_busy,
  output logic                       rd_done,
  output logic [BANK_BITS-1:0]       m_data,
  output logic [URAM_ADDR_WIDTH-1:0] m_addr,
  output logic [BANK_W-1:0]          m_bank,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [NUM_URAM-1:0]        uram_ena,
  output logic [NUM_URAM-1:0]        uram_wea,
  output logic [URAM_ADDR_WIDTH-1:0] uram_addra,
  output logic [63:0]                uram_dina,
  output logic [NUM_BANKS-1:0]       uram_enb,
  output logic [URAM_ADDR_WIDTH-1:0] uram_addrb,
  input  logic [BANK_BITS-1:0]       uram_doutb
`ifdef COL_URAM_CTRL_PERF_EN
  ,
  output logic [31:0]                perf_stall_cycles,
  output logic [31:0]                perf_issue_cycles
`endif
);

  localparam int SLOT_W = $clog2(NUM_URAM);
  localparam int W_W    = $clog2(LOAD_DEPTH * NUM_URAM) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_DRAIN} state_t;

  typedef struct packed {
    logic [URAM_ADDR_WIDTH-1:0] addr;
    logic [BANK_W-1:0]          bank;
    logic [BANK_BITS-1:0]       data;
  } fifo_ent_t;

  state_t state_q, state_d;

  logic [W_W-1:0]             w_q;
  logic                       load_err_q, load_done_q, rd_done_q;
  logic [NUM_URAM-1:0]        uram_ena_q;
  logic [URAM_ADDR_WIDTH-1:0] uram_addra_q;
  logic [63:0]                uram_dina_q;

  logic [URAM_ADDR_WIDTH-1:0] ra_q;
  logic [BANK_W-1:0]          rb_q;
  logic [RD_LATENCY:1]        vld_pipe_q;
  logic [URAM_ADDR_WIDTH-1:0] tag_addr_q [1:RD_LATENCY];
  logic [BANK_W-1:0]          tag_bank_q [1:RD_LATENCY];

  fifo_ent_t                  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           fifo_cnt_q, inflight, occ;

  logic hs, w_final, load_end, load_go, rd_go;
  logic issue, last_issue, push, pop, drain_done;

  assign load_go  = (state_q == S_IDLE) && load_start;
  assign rd_go    = (state_q == S_IDLE) && rd_start && !load_start;
  assign hs       = (state_q == S_LOAD) && s_tvalid;
  assign w_final  = (w_q == W_W'(LOAD_DEPTH * NUM_URAM - 1));
  assign load_end = hs && (w_final || s_tlast);

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= RD_LATENCY; i++) inflight = inflight + CNT_W'(vld_pipe_q[i]);
  end

  // A pop this cycle frees a slot before any new issue can land, so it counts as credit.
  assign pop        = m_valid && m_ready;
  assign push       = vld_pipe_q[RD_LATENCY];
  assign occ        = inflight + fifo_cnt_q - CNT_W'(pop);
  assign issue      = (state_q == S_READ) && (occ < CNT_W'(FIFO_DEPTH));
  assign last_issue = issue && (ra_q == URAM_ADDR_WIDTH'(READ_DEPTH - 1)) &&
                      (rb_q == BANK_W'(NUM_BANKS - 1));
  assign drain_done = (state_q == S_DRAIN) && (inflight == '0) &&
                      ((fifo_cnt_q == '0) || ((fifo_cnt_q == CNT_W'(1)) && pop));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (load_go) state_d = S_LOAD;
               else if (rd_start) state_d = S_READ;
      S_LOAD:  if (load_end) state_d = S_IDLE;
      S_READ:  if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_done_q <= drain_done;
    end
  end

  // Load side: each accepted beat becomes one registered port-A write next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q          <= '0;
      load_err_q   <= 1'b0;
      load_done_q  <= 1'b0;
      uram_ena_q   <= '0;
      uram_addra_q <= '0;
      uram_dina_q  <= '0;
    end else begin
      load_done_q <= load_end;
      uram_ena_q  <= '0;
      if (load_go) begin
        w_q        <= '0;
        load_err_q <= 1'b0;
      end
      if (hs) begin
        uram_ena_q   <= NUM_URAM'(1) << w_q[SLOT_W-1:0];
        uram_addra_q <= URAM_ADDR_WIDTH'(w_q >> SLOT_W);
        uram_dina_q  <= s_tdata;
        w_q          <= w_q + 1'b1;
        if (w_final != s_tlast) load_err_q <= 1'b1;
      end
    end
  end

  // Issue counters: bank-minor, address-major.
  always_ff @(posedge clk) begin
    if (rst || rd_go) begin
      ra_q <= '0;
      rb_q <= '0;
    end else if (issue) begin
      if (rb_q == BANK_W'(NUM_BANKS - 1)) begin
        rb_q <= '0;
        ra_q <= ra_q + 1'b1;
      end else begin
        rb_q <= rb_q + 1'b1;
      end
    end
  end

  // Tag pipe mirrors the URAM read latency; stage RD_LATENCY lines up with uram_doutb.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        tag_addr_q[i] <= '0;
        tag_bank_q[i] <= '0;
      end
    end else begin
      vld_pipe_q[1] <= issue;
      tag_addr_q[1] <= ra_q;
      tag_bank_q[1] <= rb_q;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        tag_addr_q[i] <= tag_addr_q[i-1];
        tag_bank_q[i] <= tag_bank_q[i-1];
      end
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {tag_addr_q[RD_LATENCY], tag_bank_q[RD_LATENCY], uram_doutb};
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef COL_URAM_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_issue_q;

  always_ff @(posedge clk) begin
    if (rst || rd_go) begin
      perf_stall_q <= '0;
      perf_issue_q <= '0;
    end else begin
      if (rd_busy && m_valid && !m_ready && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
      if ((uram_enb != '0) && (perf_issue_q != '1)) perf_issue_q <= perf_issue_q + 1'b1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_issue_cycles = perf_issue_q;
`endif

  assign load_busy  = (state_q == S_LOAD);
  assign s_tready   = (state_q == S_LOAD);
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign rd_busy    = (state_q == S_READ) || (state_q == S_DRAIN);
  assign rd_done    = rd_done_q;
  assign m_valid    = (fifo_cnt_q != '0);
  assign m_data     = fifo_q[rd_ptr_q].data;
  assign m_addr     = fifo_q[rd_ptr_q].addr;
  assign m_bank     = fifo_q[rd_ptr_q].bank;
  assign uram_ena   = uram_ena_q;
  assign uram_wea   = uram_ena_q;
  assign uram_addra = uram_addra_q;
  assign uram_dina  = uram_dina_q;
  assign uram_enb   = issue ? (NUM_BANKS'(1) << rb_q) : '0;
  assign uram_addrb = ra_q;

endmodule
